// File: rtl/ysyx_22050854_fetch_unit_pkg.sv
// Shared definitions for the ysyx_22050854 instruction fetch unit:
// fetch FSM state encoding, default widths, reset PC and the canonical NOP.
package ysyx_22050854_ifu_pkg;

    localparam int          ADDR_W   = 64;
    localparam int          INST_W   = 32;
    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    typedef enum logic [2:0] {
        REQ    = 3'd0,
        WAIT   = 3'd1,
        HOLD   = 3'd2,
        DRAIN  = 3'd3,
        HALTED = 3'd4
    } ifu_state_e;

endpackage

// File: rtl/ysyx_22050854_fetch_unit_if.sv
// Bus bundle of the fetch unit: instruction-memory request/response channel
// and the valid/ready instruction channel towards decode.
// master = fetch unit side, slave = memory + decode side.
interface ysyx_22050854_fetch_unit_if #(
    parameter int ADDR_W = ysyx_22050854_ifu_pkg::ADDR_W,
    parameter int INST_W = ysyx_22050854_ifu_pkg::INST_W
);
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_resp_valid;
    logic [INST_W-1:0] imem_resp_data;
    logic              inst_valid;
    logic              inst_ready;
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] inst_pc;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid, imem_resp_data,
        output inst_valid, inst, inst_pc,
        input  inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid, imem_resp_data,
        input  inst_valid, inst, inst_pc,
        output inst_ready
    );

endinterface

// File: rtl/ysyx_22050854_fetch_unit_perf.sv
// Performance counters of the fetch unit: delivered instructions and
// cycles spent waiting on instruction memory. Both wrap at 2^64.
// Only built when IFU_PERF_CNT_EN is defined.
`ifdef IFU_PERF_CNT_EN
module ysyx_22050854_ifu_perf (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_evt,
    input  logic        wait_evt,
    output logic [63:0] fetch_cnt,
    output logic [63:0] wait_cnt
);

    // Count delivery handshakes and memory-wait cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt <= 64'd0;
            wait_cnt  <= 64'd0;
        end else begin
            if (fetch_evt) begin
                fetch_cnt <= fetch_cnt + 64'd1;
            end
            if (wait_evt) begin
                wait_cnt <= wait_cnt + 64'd1;
            end
        end
    end

endmodule
`endif

// File: rtl/ysyx_22050854_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches one word at a time from
// instruction memory and hands it to decode through a one-entry buffer.
// Redirects from execute win over everything but reset; a redirect that
// leaves a request in flight goes through DRAIN to swallow its response.
// Optional performance counters are built when IFU_PERF_CNT_EN is defined;
// otherwise perf_fetch_cnt/perf_wait_cnt read as zero.
module ysyx_22050854_fetch_unit #(
    parameter int                ADDR_W   = ysyx_22050854_ifu_pkg::ADDR_W,
    parameter int                INST_W   = ysyx_22050854_ifu_pkg::INST_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ysyx_22050854_ifu_pkg::RESET_PC[ADDR_W-1:0]
) (
    input  logic                       clk,
    input  logic                       rst,
    ysyx_22050854_fetch_unit_if.master bus,
    input  logic                       redirect_valid,
    input  logic [ADDR_W-1:0]          redirect_pc,
    input  logic                       halt,
    output logic [63:0]                perf_fetch_cnt,
    output logic [63:0]                perf_wait_cnt
);
    import ysyx_22050854_ifu_pkg::*;

    ifu_state_e        state_r;
    ifu_state_e        state_s;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] pc_s;
    logic [INST_W-1:0] inst_r;
    logic [ADDR_W-1:0] inst_pc_r;
    logic              capture_s;
    logic              accept_s;
    logic [ADDR_W-1:0] redirect_target_s;

    // Instructions are word aligned; the low two bits of a target are dropped.
    assign redirect_target_s = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign accept_s          = bus.imem_req_valid && bus.imem_req_ready;

    // The request is masked during reset so nothing is issued before the
    // PC has been loaded.
    assign bus.imem_req_valid = (state_r == REQ) && !rst;
    assign bus.imem_req_addr  = pc_r;
    assign bus.inst_valid     = (state_r == HOLD);
    assign bus.inst           = inst_r;
    assign bus.inst_pc        = inst_pc_r;

    // Next-state, next-PC and capture decode; redirect is checked first in
    // every state except HALTED, which only reset leaves.
    always_comb begin
        state_s   = state_r;
        pc_s      = pc_r;
        capture_s = 1'b0;
        case (state_r)
            REQ: begin
                if (redirect_valid) begin
                    pc_s    = redirect_target_s;
                    state_s = accept_s ? DRAIN : REQ;
                end else if (accept_s) begin
                    state_s = WAIT;
                end else if (halt) begin
                    state_s = HALTED;
                end else begin
                    state_s = REQ;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    pc_s    = redirect_target_s;
                    state_s = bus.imem_resp_valid ? REQ : DRAIN;
                end else if (bus.imem_resp_valid) begin
                    capture_s = 1'b1;
                    pc_s      = pc_r + ADDR_W'(3'd4);
                    state_s   = HOLD;
                end else begin
                    state_s = WAIT;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_s    = redirect_target_s;
                    state_s = REQ;
                end else if (bus.inst_ready) begin
                    state_s = halt ? HALTED : REQ;
                end else begin
                    state_s = HOLD;
                end
            end
            DRAIN: begin
                if (redirect_valid) begin
                    pc_s    = redirect_target_s;
                    state_s = bus.imem_resp_valid ? REQ : DRAIN;
                end else if (bus.imem_resp_valid) begin
                    state_s = halt ? HALTED : REQ;
                end else begin
                    state_s = DRAIN;
                end
            end
            HALTED: begin
                state_s = HALTED;
            end
            default: begin
                state_s = REQ;
            end
        endcase
    end

    // State, PC and output buffer registers; the buffer loads only on a
    // response accepted in WAIT and otherwise holds steady for decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= REQ;
            pc_r      <= RESET_PC;
            inst_r    <= {INST_W{1'b0}};
            inst_pc_r <= {ADDR_W{1'b0}};
        end else begin
            state_r <= state_s;
            pc_r    <= pc_s;
            if (capture_s) begin
                inst_r    <= bus.imem_resp_data;
                inst_pc_r <= pc_r;
            end
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic handshake_s;
    logic mem_wait_s;

    assign handshake_s = bus.inst_valid && bus.inst_ready;
    assign mem_wait_s  = (state_r == WAIT) || (state_r == DRAIN);

    ysyx_22050854_ifu_perf u_perf (
        .clk       (clk),
        .rst       (rst),
        .fetch_evt (handshake_s),
        .wait_evt  (mem_wait_s),
        .fetch_cnt (perf_fetch_cnt),
        .wait_cnt  (perf_wait_cnt)
    );
`else
    assign perf_fetch_cnt = 64'd0;
    assign perf_wait_cnt  = 64'd0;
`endif

endmodule

// File: tb/tb_ysyx_22050854_fetch_unit.sv
// Self-checking bench for ysyx_22050854_fetch_unit. A transaction-level
// model tracks the PC of the next instruction decode must see, and an
// instruction memory model answers each accepted request after mem_lat
// cycles with a word derived from its address.
module tb_ysyx_22050854_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        halt;
    logic [63:0] perf_fetch_cnt;
    logic [63:0] perf_wait_cnt;

    int errors = 0;
    int checks = 0;

    ysyx_22050854_fetch_unit_if bus ();

    ysyx_22050854_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_wait_cnt  (perf_wait_cnt)
    );

    always #5 clk = ~clk;

    // Memory contents: a fixed ebreak-like word at the reset PC, elsewhere
    // a word derived from the address so a wrong PC shows up as wrong data.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a == 64'h0000_0000_8000_0000) return 32'h0010_0073;
        return a[31:0] ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- memory model ----------------
    logic [63:0] q_addr[$];
    int          q_due[$];
    int          cyc = 0;
    int          mem_lat = 1;

    initial begin
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'h0;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                q_addr.delete();
                q_due.delete();
            end else if (bus.imem_resp_valid && q_addr.size() > 0) begin
                void'(q_addr.pop_front());
                void'(q_due.pop_front());
            end
            #1;
            if (!rst && q_addr.size() > 0 && q_due[0] <= cyc) begin
                bus.imem_resp_valid = 1'b1;
                bus.imem_resp_data  = mem_word(q_addr[0]);
            end else begin
                bus.imem_resp_valid = 1'b0;
                bus.imem_resp_data  = 32'h0;
            end
        end
    end

    // ---------------- model + compare ----------------
    logic [63:0] exp_pc = 64'h0000_0000_8000_0000;
    bit          halted = 1'b0;
    bit          must_invalid = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                if (cyc > 0) begin
                    chk("rst_req_valid", {63'd0, bus.imem_req_valid}, 64'd0);
                    chk("rst_inst_valid", {63'd0, bus.inst_valid}, 64'd0);
                end
                exp_pc       = 64'h0000_0000_8000_0000;
                halted       = 1'b0;
                must_invalid = 1'b0;
            end else begin
                chk("req_xor_inst", {63'd0, bus.imem_req_valid && bus.inst_valid}, 64'd0);
                if (halted) begin
                    chk("halted_req", {63'd0, bus.imem_req_valid}, 64'd0);
                    chk("halted_inst", {63'd0, bus.inst_valid}, 64'd0);
                end
                if (must_invalid) begin
                    chk("post_redirect_inst_valid", {63'd0, bus.inst_valid}, 64'd0);
                end
                if (bus.imem_req_valid) begin
                    chk("model_req_addr", bus.imem_req_addr, exp_pc);
                end
                if (bus.inst_valid) begin
                    chk("model_inst_pc", bus.inst_pc, exp_pc);
                    chk("model_inst", {32'd0, bus.inst}, {32'd0, mem_word(exp_pc)});
                end
                // Events happening at the coming edge.
                if (bus.imem_req_valid && bus.imem_req_ready) begin
                    q_addr.push_back(bus.imem_req_addr);
                    q_due.push_back(cyc + mem_lat);
                end
                if (bus.inst_valid && bus.inst_ready) begin
                    exp_pc = exp_pc + 64'd4;
                end
                must_invalid = 1'b0;
                if (!halted && redirect_valid) begin
                    exp_pc       = {redirect_pc[63:2], 2'b00};
                    must_invalid = 1'b1;
                end else if (!halted && halt &&
                             ((bus.inst_valid && bus.inst_ready) ||
                              (bus.imem_req_valid && !bus.imem_req_ready))) begin
                    halted = 1'b1;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst                = 1'b1;
        bus.imem_req_ready = 1'b0;
        bus.inst_ready     = 1'b0;
        redirect_valid     = 1'b0;
        redirect_pc        = 64'd0;
        halt               = 1'b0;
        repeat (3) tick();
        chk("reset_inst_valid", {63'd0, bus.inst_valid}, 64'd0);
        chk("reset_inst", {32'd0, bus.inst}, 64'd0);
        chk("reset_inst_pc", bus.inst_pc, 64'd0);
        chk("reset_req_gated", {63'd0, bus.imem_req_valid}, 64'd0);
        rst = 1'b0;
        #1;
        chk("first_req_valid", {63'd0, bus.imem_req_valid}, 64'd1);
        chk("first_req_addr", bus.imem_req_addr, 64'h0000_0000_8000_0000);
    endtask

    initial begin
        int n;
        int guard;
        mem_lat = 1;
        do_reset();

        // Fetch from the reset PC with 1-cycle memory, then stall decode.
        bus.imem_req_ready = 1'b1;
        tick();
        tick();
        chk("t1_inst_valid", {63'd0, bus.inst_valid}, 64'd1);
        chk("t1_inst", {32'd0, bus.inst}, 64'h0000_0000_0010_0073);
        chk("t1_inst_pc", bus.inst_pc, 64'h0000_0000_8000_0000);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_hold_valid", {63'd0, bus.inst_valid}, 64'd1);
            chk("t2_hold_inst", {32'd0, bus.inst}, 64'h0000_0000_0010_0073);
            chk("t2_hold_no_req", {63'd0, bus.imem_req_valid}, 64'd0);
        end
        bus.inst_ready = 1'b1;
        tick();
        bus.inst_ready = 1'b0;
        chk("t2_next_req_valid", {63'd0, bus.imem_req_valid}, 64'd1);
        chk("t2_next_req_addr", bus.imem_req_addr, 64'h0000_0000_8000_0004);

        // Redirect while waiting; the late response must be dropped.
        mem_lat = 2;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h0000_0000_8000_0102;
        tick();
        redirect_valid = 1'b0;
        chk("t3_drain_no_req", {63'd0, bus.imem_req_valid}, 64'd0);
        chk("t3_drain_inst_valid", {63'd0, bus.inst_valid}, 64'd0);
        tick();
        chk("t3_inst_valid", {63'd0, bus.inst_valid}, 64'd0);
        chk("t3_req_valid", {63'd0, bus.imem_req_valid}, 64'd1);
        chk("t3_req_addr", bus.imem_req_addr, 64'h0000_0000_8000_0100);

        // Redirect together with a decode handshake.
        mem_lat = 1;
        tick();
        tick();
        chk("t4_inst_pc", bus.inst_pc, 64'h0000_0000_8000_0100);
        bus.inst_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h0000_0000_8000_0200;
        bus.imem_req_ready = 1'b0;
        tick();
        redirect_valid = 1'b0;
        bus.inst_ready = 1'b0;
        chk("t4_inst_valid", {63'd0, bus.inst_valid}, 64'd0);
        chk("t4_req_addr", bus.imem_req_addr, 64'h0000_0000_8000_0200);

        // Redirect in REQ without acceptance, to the top of the address space.
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFE;
        tick();
        redirect_valid = 1'b0;
        chk("t5_req_valid", {63'd0, bus.imem_req_valid}, 64'd1);
        chk("t5_req_addr", bus.imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        bus.imem_req_ready = 1'b1;
        tick();
        tick();
        chk("t5_inst_pc", bus.inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("t5_inst", {32'd0, bus.inst}, 64'h0000_0000_FFFF_FFEF);
        bus.inst_ready = 1'b1;
        tick();
        bus.inst_ready = 1'b0;
        chk("t5_wrap_addr", bus.imem_req_addr, 64'd0);

        // Redirect in the same cycle the request is accepted.
        redirect_valid = 1'b1;
        redirect_pc    = 64'h0000_0000_8000_0300;
        tick();
        redirect_valid = 1'b0;
        chk("t6_drain_no_req", {63'd0, bus.imem_req_valid}, 64'd0);
        tick();
        chk("t6_req_valid", {63'd0, bus.imem_req_valid}, 64'd1);
        chk("t6_req_addr", bus.imem_req_addr, 64'h0000_0000_8000_0300);

        // Halt while holding an instruction; redirects are ignored afterwards.
        tick();
        tick();
        chk("t7_inst_pc", bus.inst_pc, 64'h0000_0000_8000_0300);
        halt           = 1'b1;
        bus.inst_ready = 1'b1;
        tick();
        bus.inst_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            redirect_valid = (i == 3) || (i == 10);
            redirect_pc    = 64'h0000_0000_8000_0400;
            tick();
            chk("t7_halt_no_req", {63'd0, bus.imem_req_valid}, 64'd0);
            chk("t7_halt_no_inst", {63'd0, bus.inst_valid}, 64'd0);
        end
        redirect_valid = 1'b0;
        halt           = 1'b0;
        tick();
        chk("t7_stays_halted", {63'd0, bus.imem_req_valid}, 64'd0);

        // Four instructions with 2-cycle memory, then halt.
        mem_lat = 2;
        do_reset();
        bus.imem_req_ready = 1'b1;
        bus.inst_ready     = 1'b1;
        n     = 0;
        guard = 0;
        while (n < 4 && guard < 100) begin
            if (bus.inst_valid) begin
                n++;
                if (n == 4) halt = 1'b1;
            end
            tick();
            guard++;
        end
        chk("t8_delivered", 64'(n), 64'd4);
        repeat (3) tick();
`ifdef IFU_PERF_CNT_EN
        chk("t8_perf_fetch", perf_fetch_cnt, 64'd4);
        chk("t8_perf_wait", perf_wait_cnt, 64'd8);
`else
        chk("t8_perf_fetch_off", perf_fetch_cnt, 64'd0);
        chk("t8_perf_wait_off", perf_wait_cnt, 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
